// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int MAX_WAIT   = 15;
    localparam int WAIT_CNT_W = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and the responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        merged  = word;
        ld_data = '0;
        ld_b    = word[{addr_lo, 3'b000} +: 8];
        ld_h    = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SIZE_B: begin
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                ld_data = {{24{~is_unsigned & ld_b[7]}}, ld_b};
            end
            SIZE_H: begin
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                ld_data = {{16{~is_unsigned & ld_h[15]}}, ld_h};
            end
            SIZE_W: begin
                merged  = wdata;
                ld_data = word;
            end
            default: begin
                merged  = word;
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: fixed wait states, then commit to the
// word SRAM and hold the response until the consumer takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    dmem_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  we_q, we_d, uns_q, uns_d, err_q, err_d;
    mem_size_e             size_q, size_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             idle;
    logic [31:0]      acc_addr, acc_wdata, acc_off, rd_word, merged, ld_data;
    logic             acc_we, acc_uns, acc_err, commit, mem_we;
    mem_size_e        acc_size;
    logic [IDX_W-1:0] acc_idx;

    function automatic logic access_err(input logic [1:0] addr_lo, input logic [31:0] off,
                                        input mem_size_e size);
        logic e;
        case (size)
            SIZE_H:  e = addr_lo[0];
            SIZE_W:  e = (addr_lo != 2'b00);
            SIZE_X:  e = 1'b1;
            default: e = 1'b0;
        endcase
        // Addresses below BASE_ADDR wrap to a huge offset and fail here too.
        return e | (off >= SPAN);
    endfunction

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus fields feed the datapath while idle; otherwise the captured copy.
    always_comb begin
        idle      = (state_q == IDLE);
        acc_addr  = idle ? bus.req_addr : addr_q;
        acc_wdata = idle ? bus.req_wdata : wdata_q;
        acc_we    = idle ? bus.req_we : we_q;
        acc_uns   = idle ? bus.req_unsigned : uns_q;
        acc_size  = idle ? mem_size_e'(bus.req_size) : size_q;
        acc_off   = acc_addr - BASE_ADDR;
        acc_idx   = acc_off[IDX_W+1:2];
        acc_err   = access_err(acc_addr[1:0], acc_off, acc_size);
    end

    assign rd_word = mem[acc_idx];

    dmem_align u_align (
        .word        (rd_word),
        .wdata       (acc_wdata),
        .addr_lo     (acc_addr[1:0]),
        .size        (acc_size),
        .is_unsigned (acc_uns),
        .merged      (merged),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    size_d  = mem_size_e'(bus.req_size);
                    uns_d   = bus.req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        wait_cnt_d = WAIT_CNT_W'(WAIT_CYCLES);
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == WAIT_CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'h0 : ld_data;
        end
    end

    // A reset landing on the commit edge must suppress the store as well.
    assign mem_we = commit & ~acc_err & acc_we & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_B;
            uns_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) checked
// every cycle against a byte-level memory model plus literal expectations.
module tb_dmem_responder;

    localparam int ND    = 3;
    localparam int DEPTH = 64;
    localparam int SPAN  = DEPTH * 4;

    function automatic int wc_of(input int g);
        case (g)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int g);
        return (g == 1) ? 32'h0000_2000 : 32'h0000_0000;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ND-1:0] rst_v, req_valid_v, req_we_v, req_uns_v, resp_ready_v;
    logic [ND-1:0] req_ready_v, resp_valid_v, resp_err_v;
    logic [31:0]   req_addr_v [ND];
    logic [31:0]   req_wdata_v [ND];
    logic [31:0]   resp_rdata_v [ND];
    logic [1:0]    req_size_v [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_responder_if ifc ();
        assign ifc.req_valid    = req_valid_v[g];
        assign ifc.req_addr     = req_addr_v[g];
        assign ifc.req_wdata    = req_wdata_v[g];
        assign ifc.req_we       = req_we_v[g];
        assign ifc.req_size     = req_size_v[g];
        assign ifc.req_unsigned = req_uns_v[g];
        assign ifc.resp_ready   = resp_ready_v[g];
        assign req_ready_v[g]   = ifc.req_ready;
        assign resp_valid_v[g]  = ifc.resp_valid;
        assign resp_rdata_v[g]  = ifc.resp_rdata;
        assign resp_err_v[g]    = ifc.resp_err;

        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (base_of(g)),
            .WAIT_CYCLES (wc_of(g))
        ) u_dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .bus   (ifc)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        int          due;
        bit          done;
        bit          chk;
        logic [31:0] rdata;
        logic        err;
    } pend_t;

    logic [7:0] mmem [ND][SPAN];
    bit         known [ND][SPAN];
    pend_t      pend [ND];
    bit         busy [ND];

    task automatic model_commit(input int d);
        int          n;
        logic [31:0] off, v;
        n   = (pend[d].size == 2'd0) ? 1 : (pend[d].size == 2'd1) ? 2 : 4;
        off = pend[d].addr - base_of(d);
        pend[d].err   = (pend[d].size == 2'd3) || ((pend[d].addr % 32'(n)) != 0) || (off >= 32'(SPAN));
        pend[d].rdata = 32'h0;
        pend[d].chk   = 1'b1;
        if (!pend[d].err) begin
            if (pend[d].we) begin
                for (int i = 0; i < n; i++) begin
                    mmem[d][int'(off) + i]  = pend[d].wdata[8*i +: 8];
                    known[d][int'(off) + i] = 1'b1;
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) begin
                    v = v | (32'(mmem[d][int'(off) + i]) << (8 * i));
                    if (!known[d][int'(off) + i]) pend[d].chk = 1'b0;
                end
                if (!pend[d].uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                pend[d].rdata = v;
            end
        end
        pend[d].done = 1'b1;
    endtask

    // Compare process: every falling edge, every instance.
    initial begin
        for (int d = 0; d < ND; d++) busy[d] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                bit b0, ev;
                b0 = busy[d];
                if (b0 && !pend[d].done && cyc >= pend[d].due) model_commit(d);
                ev = b0 && (cyc >= pend[d].due);
                check($sformatf("d%0d_resp_valid", d), 32'(resp_valid_v[d]), 32'(ev));
                check($sformatf("d%0d_req_ready", d), 32'(req_ready_v[d]), 32'(!b0));
                if (ev && resp_valid_v[d]) begin
                    check($sformatf("d%0d_resp_err", d), 32'(resp_err_v[d]), 32'(pend[d].err));
                    if (pend[d].chk)
                        check($sformatf("d%0d_resp_rdata", d), resp_rdata_v[d], pend[d].rdata);
                end
                if (ev && resp_ready_v[d]) busy[d] = 1'b0;
                if (rst_v[d]) begin
                    busy[d] = 1'b0;
                end else if (!b0 && req_valid_v[d]) begin
                    pend[d].addr  = req_addr_v[d];
                    pend[d].wdata = req_wdata_v[d];
                    pend[d].we    = req_we_v[d];
                    pend[d].size  = req_size_v[d];
                    pend[d].uns   = req_uns_v[d];
                    pend[d].due   = cyc + 1 + wc_of(d);
                    pend[d].done  = 1'b0;
                    busy[d]       = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] w, input logic we,
                        input logic [1:0] sz, input logic u, input bit keep, output int acc);
        bit ok;
        ok = 1'b0;
        acc = cyc;
        req_addr_v[d] = a; req_wdata_v[d] = w; req_we_v[d] = we;
        req_size_v[d] = sz; req_uns_v[d] = u; req_valid_v[d] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_v[d]) begin ok = 1'b1; acc = cyc; end
        end
        if (!ok) check($sformatf("d%0d_accept_timeout", d), 32'(ok), 32'(1));
        @(posedge clk); #1;
        if (!keep) begin
            req_valid_v[d] = 1'b0;
            req_addr_v[d] = ~a; req_wdata_v[d] = ~w; req_we_v[d] = ~we;
            req_size_v[d] = ~sz; req_uns_v[d] = ~u;
        end
    endtask

    task automatic get(input int d, input int acc, output logic [31:0] rd, output logic er,
                       output int lat);
        bit ok;
        ok = 1'b0; rd = 32'h0; er = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid_v[d]) begin
                ok = 1'b1; rd = resp_rdata_v[d]; er = resp_err_v[d]; lat = cyc - acc;
            end
        end
        if (!ok) check($sformatf("d%0d_resp_timeout", d), 32'(ok), 32'(1));
        if (resp_ready_v[d]) begin @(posedge clk); #1; end
    endtask

    task automatic xfer(input int d, input string tag, input logic [31:0] a, input logic [31:0] w,
                        input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int acc, lat;
        logic [31:0] rd;
        logic er;
        send(d, a, w, we, sz, u, 1'b0, acc);
        get(d, acc, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    localparam logic [31:0] BB_ADDR [4] = '{32'h2000, 32'h2004, 32'h2006, 32'h2008};
    localparam logic [1:0]  BB_SIZE [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
    localparam logic        BB_UNS  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] BB_EXP  [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_89AB, 32'h0000_000D};

    initial begin
        int acc, prev_acc, lat;
        logic [31:0] rd;
        logic er;
        rst_v = '1; req_valid_v = '0; req_we_v = '0; req_uns_v = '0; resp_ready_v = '1;
        for (int d = 0; d < ND; d++) begin
            req_addr_v[d] = '0; req_wdata_v[d] = '0; req_size_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_v = '0;

        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_rst_resp_valid", d), 32'(resp_valid_v[d]), 32'(0));
            check($sformatf("d%0d_rst_req_ready", d), 32'(req_ready_v[d]), 32'(1));
            check($sformatf("d%0d_rst_rdata", d), resp_rdata_v[d], 32'h0);
            check($sformatf("d%0d_rst_err", d), 32'(resp_err_v[d]), 32'(0));
        end
        @(posedge clk); #1;

        // One wait state: word, byte and half accesses.
        xfer(0, "w1_st_word", 32'h10, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 2);
        xfer(0, "w1_ld_word", 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        xfer(0, "w1_ld_uhalf", 32'h10, 32'h0, 1'b0, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0, 2);
        xfer(0, "w1_st_byte", 32'h12, 32'hAAAA_AA7F, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 2);
        xfer(0, "w1_ld_shalf", 32'h12, 32'h0, 1'b0, 2'd1, 1'b0, 32'hFFFF_DE7F, 1'b0, -1);
        xfer(0, "w1_ld_ubyte13", 32'h13, 32'h0, 1'b0, 2'd0, 1'b1, 32'h0000_00DE, 1'b0, -1);
        xfer(0, "w1_ld_sbyte12", 32'h12, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0000_007F, 1'b0, -1);
        xfer(0, "w1_ld_sbyte13", 32'h13, 32'h0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFDE, 1'b0, -1);

        // Error cases leave memory untouched.
        xfer(0, "w1_err_mis_word", 32'h11, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, -1);
        xfer(0, "w1_err_mis_half", 32'h13, 32'h0000_5555, 1'b1, 2'd1, 1'b0, 32'h0, 1'b1, -1);
        xfer(0, "w1_err_size3", 32'h10, 32'h1234_5678, 1'b1, 2'd3, 1'b0, 32'h0, 1'b1, -1);
        xfer(0, "w1_err_range", 32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, -1);
        xfer(0, "w1_ld_after_err", 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDE7F_BEEF, 1'b0, -1);

        // Backpressure on the response channel.
        resp_ready_v[0] = 1'b0;
        send(0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, acc);
        get(0, acc, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(resp_valid_v[0]), 32'(1));
            check("bp_rdata", resp_rdata_v[0], 32'hDE7F_BEEF);
            check("bp_req_ready", 32'(req_ready_v[0]), 32'(0));
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 resp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(req_ready_v[0]), 32'(1));
        check("bp_release_valid", 32'(resp_valid_v[0]), 32'(0));

        // Zero wait states, base 0x2000: back-to-back loads with req_valid held.
        xfer(1, "w0_st0", 32'h2000, 32'h0123_4567, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1);
        xfer(1, "w0_st1", 32'h2004, 32'h89AB_CDEF, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1);
        xfer(1, "w0_st2", 32'h2008, 32'h0BAD_F00D, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1);
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(1, BB_ADDR[i], 32'h0, 1'b0, BB_SIZE[i], BB_UNS[i], (i < 3), acc);
            check($sformatf("bb%0d_resp_valid", i), 32'(resp_valid_v[1]), 32'(1));
            check($sformatf("bb%0d_rdata", i), resp_rdata_v[1], BB_EXP[i]);
            if (i > 0) check($sformatf("bb%0d_accept_gap", i), 32'(acc - prev_acc), 32'(2));
            prev_acc = acc;
        end
        @(posedge clk); #1;
        xfer(1, "w0_err_wrap", 32'h1FFC, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 1);
        xfer(1, "w0_err_top", 32'h2100, 32'h0, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, -1);

        // Three wait states, reset while a store is waiting.
        xfer(2, "w3_st", 32'h20, 32'h1122_3344, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 4);
        xfer(2, "w3_ld", 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1122_3344, 1'b0, 4);
        send(2, 32'h20, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 1'b0, acc);
        rst_v[2] = 1'b1;
        @(posedge clk); #1 rst_v[2] = 1'b0;
        @(negedge clk);
        check("w3_rst_resp_valid", 32'(resp_valid_v[2]), 32'(0));
        check("w3_rst_req_ready", 32'(req_ready_v[2]), 32'(1));
        check("w3_rst_rdata", resp_rdata_v[2], 32'h0);
        check("w3_rst_err", 32'(resp_err_v[2]), 32'(0));
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        xfer(2, "w3_ld_after_rst", 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1122_3344, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
